// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channel choice is either a static index (mode=0) or round-robin arbitration (mode=1).
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  // state | meaning
  // EMPTY | output register holds no word
  // FULL  | output register holds a word awaiting out_ready
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;

  ostate_t          state, state_nxt;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_pick;
  logic             rr_found;
  int               rr_idx;
  logic [SELW-1:0]  chosen;
  logic             chosen_ok;
  logic [WIDTH-1:0] chosen_data;
  logic             load_en;
  logic             grant;

  assign out_valid = (state == FULL);
  assign load_en   = !out_valid | out_ready;

  // First valid channel at or after rr_ptr, wrapping
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = 0;
    for (int i = 0; i < N; i++) begin
      rr_idx = (int'(rr_ptr) + i) % N;
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = SELW'(rr_idx);
      end
    end
  end

  always_comb begin
    chosen    = sel;
    chosen_ok = (32'(sel) < N);
    if (mode) begin
      chosen    = rr_pick;
      chosen_ok = rr_found;
    end
  end

  always_comb begin
    chosen_data = '0;
    in_ready    = '0;
    for (int g = 0; g < N; g++) begin
      if (SELW'(g) == chosen) begin
        chosen_data = in_data[g*WIDTH +: WIDTH];
        in_ready[g] = !rst & load_en & chosen_ok;
      end
    end
  end

  assign grant = |(in_ready & in_valid);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_chan <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      out_data <= chosen_data;
      out_chan <= chosen;
      if (mode) rr_ptr <= (32'(chosen) == N - 1) ? '0 : chosen + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: expected words are queued at issue time and
// popped by a monitor at each output handshake; a second 3-channel instance covers illegal sel.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  logic        mode3;
  logic [1:0]  sel3;
  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;

  typedef struct packed {
    logic [1:0] chan;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3:0] chdat [4] = '{4'h1, 4'h5, 4'hA, 4'hF};

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(4), .N(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  stream_mux_rr #(.WIDTH(4), .N(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_chan(out_chan3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch);
    exp_t e;
    e.chan = 2'(ch);
    e.data = chdat[ch];
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got chan=%0d data=%0h, expected no word", out_chan, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_chan", 32'(out_chan), 32'(e.chan));
        check("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; out_ready = 1'b0;
    in_data = {chdat[3], chdat[2], chdat[1], chdat[0]};
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b0; out_ready3 = 1'b0;
    in_data3 = {4'h9, 4'h6, 4'h3};

    step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_chan", 32'(out_chan), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;

    // static select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1 check("static_in_ready", 32'(in_ready), 32'b0100);
    push(2);
    step();
    check("static_out_data", 32'(out_data), 32'hA);
    check("static_out_chan", 32'(out_chan), 2);
    in_valid = 4'b0;
    step();

    // round-robin fairness, all channels valid
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push(i % 4);
      step();
      check("rr_out_valid", 32'(out_valid), 1);
      check("rr_out_chan", 32'(out_chan), 32'(i % 4));
    end
    in_valid = 4'b0;
    step();

    // skip and wrap: move rr_ptr to 3, then only ch0/ch1 valid
    in_valid = 4'b0100;
    push(2);
    step();
    in_valid = 4'b0011;
    #1 check("wrap_in_ready0", 32'(in_ready), 32'b0001);
    push(0);
    step();
    check("wrap_in_ready1", 32'(in_ready), 32'b0010);
    push(1);
    step();
    in_valid = 4'b0;
    step();

    // backpressure with rr_ptr=2
    out_ready = 1'b0; in_valid = 4'b1111;
    #1 check("bp_first_in_ready", 32'(in_ready), 32'b0100);
    push(2);
    step();
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_data", 32'(out_data), 32'hA);
      check("bp_out_chan", 32'(out_chan), 2);
      check("bp_out_valid", 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", 32'(in_ready), 32'b1000);
    push(3);
    step();
    check("bp_reload_chan", 32'(out_chan), 3);
    check("bp_reload_valid", 32'(out_valid), 1);
    in_valid = 4'b0;
    step();

    // async reset while a word is held; rr_ptr advanced to 2 beforehand
    out_ready = 1'b0; in_valid = 4'b0010;
    #1 check("mid_in_ready", 32'(in_ready), 32'b0010);
    push(1);
    step();
    in_valid = 4'b1111; out_ready = 1'b1;
    check("mid_out_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_data", 32'(out_data), 0);
    check("arst_out_chan", 32'(out_chan), 0);
    check("arst_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    push(0);
    step();
    check("post_rst_chan", 32'(out_chan), 0);
    in_valid = 4'b0;
    step();

    // N=3 instance: illegal sel=3, then legal sel=1
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("ill_in_ready", 32'(in_ready3), 0);
      step();
      check("ill_out_valid", 32'(out_valid3), 0);
    end
    sel3 = 2'd1;
    #1 check("n3_in_ready", 32'(in_ready3), 32'b010);
    step();
    check("n3_out_valid", 32'(out_valid3), 1);
    check("n3_out_data", 32'(out_data3), 32'h6);
    check("n3_out_chan", 32'(out_chan3), 1);
    in_valid3 = 3'b0;
    step();

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
